line_compactor: RTL



---
 rtl/tetris_pkg.sv | 27 ++
 rtl/board_addr.sv | 18 +
 rtl/line_compactor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, cell encoding and row-compactor FSM states
// for the blocks that walk the Tetris board RAM.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 24;
  localparam int CELL_W  = 6;

  localparam logic [CELL_W-1:0] EMPTY_CELL = '0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    WRITE,
    FILL,
    DONE
  } state_t;

  // Row-major linear cell index: y*w + x.
  function automatic int unsigned cell_index(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/board_addr.sv
// Combinational (x,y) to board RAM address mapper, shared by every block
// that walks the board row by row.
module board_addr
  import tetris_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int ADDR_W  = 8,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  assign addr = ADDR_W'(cell_index(32'(x), 32'(y), 32'(BOARD_W)));

endmodule

// File: rtl/line_compactor.sv
// Row-clear engine: one bottom-to-top pass over the board RAM that drops full
// rows, slides survivors down and zero-fills the freed rows at the top.
module line_compactor
  import tetris_pkg::*;
#(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H,
  parameter int CELL_W  = tetris_pkg::CELL_W,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = $clog2(BOARD_H + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CELL_W-1:0]  ram_q,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [CELL_W-1:0]  ram_data,
  output logic               ram_wren,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   rows_cleared,
  output logic [BOARD_H-1:0] cleared_mask,
  output state_t             state_dbg
);

  // Handshake: start is a single-cycle request honoured only in IDLE (ignored
  // while busy, never queued); done pulses once per pass, busy covers the pass.

  localparam int RW = $clog2(BOARD_H);
  localparam int XW = $clog2(BOARD_W + 1);
  localparam logic [XW-1:0] LAST_X  = XW'(BOARD_W - 1);
  localparam logic [XW-1:0] READ_END = XW'(BOARD_W);
  localparam logic [RW-1:0] BOT_ROW = RW'(BOARD_H - 1);

  state_t              state, nxt_state;
  logic [XW-1:0]       col, nxt_col;
  logic [RW-1:0]       rd_row, nxt_rd;
  logic [RW:0]         wr_row, nxt_wr;
  logic                full, nxt_full;
  logic [CNT_W-1:0]    nxt_cnt;
  logic [BOARD_H-1:0]  nxt_mask;
  logic                tail;
  logic [RW-1:0]       nxt_y;
  logic [ADDR_W-1:0]   map_addr;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [CELL_W-1:0]   nxt_data;
  logic                nxt_wren;
  logic [CELL_W-1:0]   row_buf [BOARD_W];

  assign state_dbg = state;

  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_rd    = rd_row;
    nxt_wr    = wr_row;
    nxt_full  = full;
    nxt_cnt   = rows_cleared;
    nxt_mask  = cleared_mask;
    tail      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = READ;
          nxt_col   = '0;
          nxt_rd    = BOT_ROW;
          nxt_wr    = {1'b0, BOT_ROW};
          nxt_full  = 1'b1;
          nxt_cnt   = '0;
          nxt_mask  = '0;
        end
      end
      READ: begin
        // Read data lags the address by one cycle, so col k checks cell k-1.
        if (col != '0) nxt_full = full & (ram_q != CELL_W'(EMPTY_CELL));
        if (col == READ_END) nxt_state = EVAL;
        else nxt_col = col + XW'(1);
      end
      EVAL: begin
        nxt_col = '0;
        if (full) begin
          nxt_cnt          = rows_cleared + CNT_W'(1);
          nxt_mask[rd_row] = 1'b1;
          tail             = 1'b1;
        end else if ({1'b0, rd_row} != wr_row) begin
          nxt_state = WRITE;
        end else begin
          nxt_wr = wr_row - (RW+1)'(1);
          tail   = 1'b1;
        end
      end
      WRITE: begin
        if (col == LAST_X) begin
          nxt_col = '0;
          nxt_wr  = wr_row - (RW+1)'(1);
          tail    = 1'b1;
        end else begin
          nxt_col = col + XW'(1);
        end
      end
      FILL: begin
        if (col == LAST_X) begin
          nxt_col = '0;
          if (wr_row == '0) nxt_state = DONE;
          else nxt_wr = wr_row - (RW+1)'(1);
        end else begin
          nxt_col = col + XW'(1);
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    // Shared end-of-row step for EVAL and WRITE.
    if (tail) begin
      if (rd_row == '0) begin
        nxt_state = (nxt_cnt != '0) ? FILL : DONE;
      end else begin
        nxt_rd    = rd_row - RW'(1);
        nxt_full  = 1'b1;
        nxt_state = READ;
      end
    end
  end

  // Outputs are computed from next-state values so the registered port
  // lines up with the state it belongs to.
  assign nxt_y = (nxt_state == READ) ? nxt_rd : nxt_wr[RW-1:0];

  board_addr #(
    .BOARD_W (BOARD_W),
    .ADDR_W  (ADDR_W),
    .X_W     (XW),
    .Y_W     (RW)
  ) u_board_addr (
    .x    (nxt_col),
    .y    (nxt_y),
    .addr (map_addr)
  );

  always_comb begin
    nxt_wren = (nxt_state == WRITE) || (nxt_state == FILL);
    nxt_addr = '0;
    nxt_data = '0;
    if (nxt_state == READ || nxt_wren) nxt_addr = map_addr;
    if (nxt_state == WRITE) nxt_data = row_buf[nxt_col];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      rd_row       <= '0;
      wr_row       <= '0;
      full         <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      ram_wren     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rows_cleared <= '0;
      cleared_mask <= '0;
    end else begin
      state        <= nxt_state;
      col          <= nxt_col;
      rd_row       <= nxt_rd;
      wr_row       <= nxt_wr;
      full         <= nxt_full;
      ram_addr     <= nxt_addr;
      ram_data     <= nxt_data;
      ram_wren     <= nxt_wren;
      busy         <= (nxt_state != IDLE);
      done         <= (nxt_state == DONE);
      rows_cleared <= nxt_cnt;
      cleared_mask <= nxt_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (state == READ && col != '0) row_buf[col - XW'(1)] <= ram_q;
  end

endmodule
